uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one UART transmitter (the `UART_N`/`UART_E` TX side) between several requesters. It performs a valid/ready handshake with each requester and latches the granted word. It then drives the UART `write`/`T_W` pair until the UART reports `T_locked`, and waits for the frame to drain before granting again. It sits between the system-side producers (CPU port, debug, DMA) and the UART instance.

---
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between several requesters.
// Optional ISSUE timeout is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int requesters     = 4,
  parameter int word_width     = 8,
  parameter int timeout_cycles = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [requesters-1:0]            req_valid,
  input  logic [requesters*word_width-1:0] req_data,
  output logic [requesters-1:0]            req_ready,
  output logic                             uart_write,
  output logic [word_width-1:0]            uart_T_W,
  input  logic                             uart_T_locked,
  output logic [$clog2(requesters)-1:0]    grant_id,
  output logic                             busy,
  output logic                             timeout_err
);
  localparam int PW = $clog2(requesters);

  // Handshake: a requester's word is accepted on a rising clk edge where
  // req_valid[i] & req_ready[i]; req_data must hold steady while req_valid is high.
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         rr_ptr, rr_ptr_nxt, grant_id_nxt, gnt, next_ptr;
  logic [word_width-1:0] hold, hold_nxt;
  logic                  write_nxt, busy_nxt, found;
  int                    idx;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          tmo_nxt;
`endif

  // First valid port at or above rr_ptr, wrapping past the top port.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < requesters; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= requesters) idx = idx - requesters;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx[PW-1:0];
      end
    end
  end

  assign next_ptr = (grant_id == PW'(requesters - 1)) ? '0 : grant_id + 1'b1;
  assign uart_T_W = hold;

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    hold_nxt     = hold;
    grant_id_nxt = grant_id;
    write_nxt    = uart_write;
    busy_nxt     = busy;
    req_ready    = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_nxt      = cnt;
    tmo_nxt      = 1'b0;
`endif
    case (state)
      IDLE: begin
        // rst_n gating keeps req_ready quiet while reset is held.
        if (found && !uart_T_locked && rst_n) begin
          req_ready[gnt] = 1'b1;
          hold_nxt       = req_data[gnt*word_width +: word_width];
          grant_id_nxt   = gnt;
          write_nxt      = 1'b1;
          busy_nxt       = 1'b1;
          state_nxt      = ISSUE;
`ifdef UART_TX_ARB_TIMEOUT_EN
          cnt_nxt        = '0;
`endif
        end
      end
      ISSUE: begin
        if (uart_T_locked) begin
          write_nxt = 1'b0;
          state_nxt = DRAIN;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (cnt == CW'(timeout_cycles - 1)) begin
          tmo_nxt    = 1'b1;
          write_nxt  = 1'b0;
          busy_nxt   = 1'b0;
          hold_nxt   = '0;
          rr_ptr_nxt = next_ptr;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      DRAIN: begin
        if (!uart_T_locked) begin
          busy_nxt   = 1'b0;
          rr_ptr_nxt = next_ptr;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      hold       <= '0;
      grant_id   <= '0;
      uart_write <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      hold       <= hold_nxt;
      grant_id   <= grant_id_nxt;
      uart_write <= write_nxt;
      busy       <= busy_nxt;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      timeout_err <= tmo_nxt;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed vectors, expected words queued
// at stimulus time and checked by a monitor on each rising uart_write.
module tb_uart_tx_arbiter;
  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        uart_write;
  logic [7:0]  uart_T_W;
  logic        uart_T_locked;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] exp_q[$];

  uart_tx_arbiter #(
    .requesters(4), .word_width(8), .timeout_cycles(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .uart_write(uart_write), .uart_T_W(uart_T_W),
    .uart_T_locked(uart_T_locked), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every new UART word must match the head of the expected queue.
  initial begin
    logic       prev_w;
    logic [9:0] exp;
    prev_w = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_write && !prev_w) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL uart_word: got %0h required none (queue empty)", {grant_id, uart_T_W});
        end else begin
          exp = exp_q.pop_front();
          check("uart_word", {22'd0, grant_id, uart_T_W}, {22'd0, exp});
        end
      end
      prev_w = uart_write;
    end
  end

  // Wait for a grant to port id, then play one UART frame against it.
  task automatic serve(input int id, input logic [7:0] word, input bit keep);
    int n;
    n = 0;
    while (req_ready == 4'b0000 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", {28'd0, req_ready}, 32'd1 << id);
    @(negedge clk);
    check("write_rise", {31'd0, uart_write}, 1);
    check("busy_issue", {31'd0, busy}, 1);
    if (!keep) req_valid = 4'b0000;
    repeat (2) begin
      @(negedge clk);
      check("write_hold", {31'd0, uart_write}, 1);
    end
    uart_T_locked = 1'b1;
    @(negedge clk);
    check("write_fall", {31'd0, uart_write}, 0);
    check("busy_drain", {31'd0, busy}, 1);
    check("tw_drain", {24'd0, uart_T_W}, {24'd0, word});
    check("grant_id", {30'd0, grant_id}, id);
    repeat (3) @(negedge clk);
    uart_T_locked = 1'b0;
    @(negedge clk);
    check("busy_idle", {31'd0, busy}, 0);
  endtask

  initial begin
    int n;
    rst_n         = 1'b0;
    uart_T_locked = 1'b0;
    req_valid     = 4'b1111;
    req_data      = {8'h13, 8'h12, 8'h11, 8'h10};

    // Reset state with every port requesting
    repeat (3) @(negedge clk);
    check("rst_ready", {28'd0, req_ready}, 0);
    check("rst_write", {31'd0, uart_write}, 0);
    check("rst_tw", {24'd0, uart_T_W}, 0);
    check("rst_grant", {30'd0, grant_id}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_tmo", {31'd0, timeout_err}, 0);

    // Fairness: continuous load serves 0,1,2,3,0
    exp_q.push_back({2'd0, 8'h10});
    exp_q.push_back({2'd1, 8'h11});
    exp_q.push_back({2'd2, 8'h12});
    exp_q.push_back({2'd3, 8'h13});
    exp_q.push_back({2'd0, 8'h10});
    rst_n = 1'b1;
    #1;
    check("rel_ready", {28'd0, req_ready}, 4'b0001);
    check("rel_grant", {30'd0, grant_id}, 0);
    serve(0, 8'h10, 1'b1);
    serve(1, 8'h11, 1'b1);
    serve(2, 8'h12, 1'b1);
    serve(3, 8'h13, 1'b1);
    serve(0, 8'h10, 1'b0);

    // Single port: port 2 sends A5
    req_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    req_valid = 4'b0100;
    exp_q.push_back({2'd2, 8'hA5});
    #1;
    serve(2, 8'hA5, 1'b0);

    // Lock interlock: no grant while T_locked is high in IDLE
    @(negedge clk);
    uart_T_locked = 1'b1;
    req_data  = {8'h00, 8'h00, 8'h5A, 8'h00};
    req_valid = 4'b0010;
    exp_q.push_back({2'd1, 8'h5A});
    #1;
    repeat (4) begin
      check("lock_block", {28'd0, req_ready}, 0);
      @(negedge clk);
    end
    uart_T_locked = 1'b0;
    #1;
    serve(1, 8'h5A, 1'b0);

    // Wrap: rr_ptr is 2, only port 0 valid
    req_data  = {8'h00, 8'h00, 8'h00, 8'h77};
    req_valid = 4'b0001;
    exp_q.push_back({2'd0, 8'h77});
    #1;
    serve(0, 8'h77, 1'b0);

    // Reset during DRAIN of 3C
    req_data  = {8'h00, 8'h00, 8'h3C, 8'h00};
    req_valid = 4'b0010;
    exp_q.push_back({2'd1, 8'h3C});
    #1;
    n = 0;
    while (req_ready == 4'b0000 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_ready", {28'd0, req_ready}, 4'b0010);
    @(negedge clk);
    check("mid_write", {31'd0, uart_write}, 1);
    req_valid     = 4'b0000;
    uart_T_locked = 1'b1;
    @(negedge clk);
    check("mid_drain_write", {31'd0, uart_write}, 0);
    check("mid_drain_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_write", {31'd0, uart_write}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    req_data      = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid     = 4'b1111;
    uart_T_locked = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", {28'd0, req_ready}, 0);
    check("mid_rst_grant", {30'd0, grant_id}, 0);
    exp_q.push_back({2'd0, 8'h10});
    rst_n = 1'b1;
    #1;
    serve(0, 8'h10, 1'b0);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Timeout: port 1 never locks, port 2 granted next
    req_data  = {8'h00, 8'h22, 8'h21, 8'h00};
    req_valid = 4'b0110;
    exp_q.push_back({2'd1, 8'h21});
    exp_q.push_back({2'd2, 8'h22});
    #1;
    n = 0;
    while (req_ready == 4'b0000 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tmo_ready", {28'd0, req_ready}, 4'b0010);
    @(negedge clk);
    req_valid = 4'b0100;
    check("tmo_write", {31'd0, uart_write}, 1);
    repeat (15) @(negedge clk);
    check("tmo_last_write", {31'd0, uart_write}, 1);
    check("tmo_not_yet", {31'd0, timeout_err}, 0);
    @(negedge clk);
    check("tmo_pulse", {31'd0, timeout_err}, 1);
    check("tmo_write_low", {31'd0, uart_write}, 0);
    check("tmo_busy_low", {31'd0, busy}, 0);
    serve(2, 8'h22, 1'b0);
    check("tmo_cleared", {31'd0, timeout_err}, 0);
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
